// File: rtl/bit_stream_tx.sv
// Serial framer: sync pattern then payload, MSB first, on one line.
// Back-to-back words are chained with no idle gap between frames.
module bit_stream_tx #(
  parameter int DATA_W = 16,
  parameter int SYNC_W = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA7,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              frame_done,
  output logic              busy,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int MW = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
  localparam int BW = (MW > 1) ? $clog2(MW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            st;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] data_sh;
  logic [SYNC_W-1:0] sync_sh;
  logic              last;
  logic              accept;

  assign last = (st == DATA) &&
                (bit_cnt == BW'(DATA_W - 1));

  // Gated by rst_n so nothing looks acceptable while held in reset.
  assign in_ready = rst_n && en &&
                    ((st == IDLE) || last);
  assign accept   = in_valid && in_ready;
  assign busy     = (st != IDLE);
  assign state    = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      bit_cnt    <= '0;
      data_sh    <= '0;
      sync_sh    <= '0;
      dout       <= 1'b0;
      dout_en    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (st)
        IDLE: begin
          dout    <= 1'b0;
          dout_en <= 1'b0;
        end
        SYNC: begin
          if (bit_cnt == BW'(SYNC_W - 1)) begin
            st      <= DATA;
            bit_cnt <= '0;
            dout    <= data_sh[DATA_W-1];
            data_sh <= data_sh << 1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            dout    <= sync_sh[SYNC_W-1];
            sync_sh <= sync_sh << 1;
          end
        end
        DATA: begin
          if (last) begin
            st      <= IDLE;
            bit_cnt <= '0;
            dout    <= 1'b0;
            dout_en <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            dout    <= data_sh[DATA_W-1];
            data_sh <= data_sh << 1;
            // Registered so it lands with the last bit.
            if (bit_cnt == BW'(DATA_W - 2)) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          st      <= IDLE;
          bit_cnt <= '0;
          dout    <= 1'b0;
          dout_en <= 1'b0;
        end
      endcase
      if (accept) begin
        st      <= SYNC;
        bit_cnt <= '0;
        data_sh <= in_data;
        sync_sh <= SYNC_PAT << 1;
        dout    <= SYNC_PAT[SYNC_W-1];
        dout_en <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bit_stream_tx.sv
// Directed bench for bit_stream_tx: framing, chaining,
// enable gating, async reset and counter wrap.
module tb_bit_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        dout;
  logic        dout_en;
  logic        frame_done;
  logic        busy;
  logic [1:0]  state;
  logic [7:0]  frame_cnt;

  int n_chk = 0;
  int n_fail = 0;

  bit_stream_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_en    (dout_en),
    .frame_done (frame_done),
    .busy       (busy),
    .state      (state),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    en       = 1'b1;
    in_valid = 1'($urandom);
    in_data  = 16'($urandom);
    tick();
    tick();
    n_chk++;
    if ({dout, dout_en, frame_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset outs: got %b want 000",
               {dout, dout_en, frame_done});
    end
    n_chk++;
    if (frame_cnt !== 8'd0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset cnt/state: got %0d/%0d want 0/0",
               frame_cnt, state);
    end
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset in_ready: got %b want 0", in_ready);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset release in_ready: got %b want 1",
               in_ready);
    end
  endtask

  task automatic test_single;
    logic [23:0] exp;
    exp      = {8'hA7, 16'hB5C3};
    en       = 1'b1;
    in_data  = 16'hB5C3;
    in_valid = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      n_chk++;
      if (dout !== exp[23-i] || dout_en !== 1'b1) begin
        n_fail++;
        $display("FAIL single bit %0d: got %b/%b want %b/1",
                 i, dout, dout_en, exp[23-i]);
      end
      n_chk++;
      if (frame_done !== (i == 23)) begin
        n_fail++;
        $display("FAIL single frame_done cyc %0d: got %b want %b",
                 i + 1, frame_done, (i == 23));
      end
      n_chk++;
      if (in_ready !== (i == 23)) begin
        n_fail++;
        $display("FAIL single in_ready cyc %0d: got %b want %b",
                 i + 1, in_ready, (i == 23));
      end
      tick();
    end
    n_chk++;
    if (frame_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL single frame_cnt: got %0d want 1", frame_cnt);
    end
    n_chk++;
    if (dout_en !== 1'b0 || dout !== 1'b0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL single idle: got en=%b d=%b st=%0d want 0/0/0",
               dout_en, dout, state);
    end
  endtask

  task automatic test_back_to_back;
    logic [47:0] exp;
    exp      = {8'hA7, 16'hFFFF, 8'hA7, 16'h0001};
    en       = 1'b1;
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    #1;
    tick();
    in_data = 16'h0001;
    for (int i = 0; i < 48; i++) begin
      n_chk++;
      if (dout !== exp[47-i] || dout_en !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b bit %0d: got %b/%b want %b/1",
                 i, dout, dout_en, exp[47-i]);
      end
      n_chk++;
      if (frame_done !== (i == 23 || i == 47)) begin
        n_fail++;
        $display("FAIL b2b frame_done cyc %0d: got %b want %b",
                 i + 1, frame_done, (i == 23 || i == 47));
      end
      tick();
      if (i == 23) in_valid = 1'b0;
    end
    n_chk++;
    if (frame_cnt !== 8'd2 || dout_en !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b end: got cnt=%0d en=%b want 2/0",
               frame_cnt, dout_en);
    end
  endtask

  task automatic test_enable_drop;
    logic [23:0] exp;
    exp      = {8'hA7, 16'h1234};
    en       = 1'b1;
    in_data  = 16'h1234;
    in_valid = 1'b1;
    #1;
    tick();
    in_data = 16'h5678;
    for (int i = 0; i < 24; i++) begin
      if (i == 13) en = 1'b0;
      #1;
      n_chk++;
      if (dout !== exp[23-i] || dout_en !== 1'b1) begin
        n_fail++;
        $display("FAIL endrop bit %0d: got %b/%b want %b/1",
                 i, dout, dout_en, exp[23-i]);
      end
      n_chk++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL endrop in_ready cyc %0d: got %b want 0",
                 i + 1, in_ready);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (state !== 2'd0 || dout_en !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL endrop hold: got st=%0d en=%b rdy=%b want 0/0/0",
                 state, dout_en, in_ready);
      end
      tick();
    end
    en = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL endrop reenable in_ready: got %b want 1",
               in_ready);
    end
    tick();
    in_valid = 1'b0;
    exp = {8'hA7, 16'h5678};
    for (int i = 0; i < 24; i++) begin
      n_chk++;
      if (dout !== exp[23-i] || dout_en !== 1'b1) begin
        n_fail++;
        $display("FAIL endrop word2 bit %0d: got %b/%b want %b/1",
                 i, dout, dout_en, exp[23-i]);
      end
      tick();
    end
    n_chk++;
    if (frame_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL endrop frame_cnt: got %0d want 2", frame_cnt);
    end
  endtask

  task automatic test_async_reset;
    logic [23:0] exp;
    en       = 1'b1;
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    n_chk++;
    if (dout !== 1'b1 || state !== 2'd2 || frame_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL arst pre: got d=%b st=%0d cnt=%0d want 1/2/2",
               dout, state, frame_cnt);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (dout !== 1'b0 || dout_en !== 1'b0) begin
      n_fail++;
      $display("FAIL arst outs: got %b/%b want 0/0", dout, dout_en);
    end
    n_chk++;
    if (state !== 2'd0 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL arst st/cnt: got %0d/%0d want 0/0",
               state, frame_cnt);
    end
    tick();
    rst_n    = 1'b1;
    in_data  = 16'hC001;
    in_valid = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    exp = {8'hA7, 16'hC001};
    for (int i = 0; i < 24; i++) begin
      n_chk++;
      if (dout !== exp[23-i] || dout_en !== 1'b1) begin
        n_fail++;
        $display("FAIL arst frame bit %0d: got %b/%b want %b/1",
                 i, dout, dout_en, exp[23-i]);
      end
      tick();
    end
    n_chk++;
    if (frame_cnt !== 8'd1 || dout_en !== 1'b0) begin
      n_fail++;
      $display("FAIL arst end: got cnt=%0d en=%b want 1/0",
               frame_cnt, dout_en);
    end
  endtask

  task automatic test_wrap;
    logic [23:0] exp;
    int gaps, bad, pulses, cnt_bad;
    gaps = 0; bad = 0; pulses = 0; cnt_bad = 0;
    exp      = {8'hA7, 16'h5A3C};
    en       = 1'b1;
    in_data  = 16'h5A3C;
    in_valid = 1'b1;
    #1;
    tick();
    for (int i = 0; i < 256 * 24; i++) begin
      if (dout_en !== 1'b1) gaps++;
      if (dout !== exp[23 - (i % 24)]) bad++;
      if (frame_done !== ((i % 24) == 23)) bad++;
      if (frame_done === 1'b1) begin
        pulses++;
        if (frame_cnt !== 8'(pulses)) cnt_bad++;
      end
      if (i == 256 * 24 - 1) in_valid = 1'b0;
      tick();
    end
    n_chk++;
    if (gaps != 0 || bad != 0) begin
      n_fail++;
      $display("FAIL wrap stream: got gaps=%0d bad=%0d want 0/0",
               gaps, bad);
    end
    n_chk++;
    if (pulses != 256 || cnt_bad != 0) begin
      n_fail++;
      $display("FAIL wrap pulses: got %0d (cnt errs %0d) want 256/0",
               pulses, cnt_bad);
    end
    n_chk++;
    if (frame_cnt !== 8'd0 || dout_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap end: got cnt=%0d en=%b want 0/0",
               frame_cnt, dout_en);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_single();
    test_reset();
    test_back_to_back();
    test_reset();
    test_enable_drop();
    test_async_reset();
    test_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_stream_tx.md
Name: bit_stream_tx

Overview:
Serial bit-stream transmitter that produces the stream consumed by the team's bit-stream lock detector. It accepts parallel data words over a valid/ready handshake. For each word it emits a fixed sync pattern on one serial line, MSB first, then the word itself, MSB first, so the downstream detector can acquire and hold lock. Back-to-back words produce a gapless stream.

Parameters:
DATA_W, 16, payload bits per frame
SYNC_W, 8, sync pattern length in bits
SYNC_PAT, 8'hA7, sync pattern sent before every payload, MSB first
CNT_W, 8, width of the frame counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  transmit enable; gates acceptance of new words only
in_data  input  DATA_W  payload word
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle (combinational)
dout  output  1  serial bit, registered; feeds detector din
dout_en  output  1  dout carries a frame bit, registered; feeds detector en
frame_done  output  1  one-cycle pulse on the last payload bit
busy  output  1  state != IDLE
state  output  2  FSM state: 0=IDLE, 1=SYNC, 2=DATA
frame_cnt  output  CNT_W  completed-frame count, wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE, dout=0, dout_en=0, frame_done=0, frame_cnt=0, shift/bit counters=0. Takes effect immediately, including mid-frame. A partial frame is dropped, not resumed.
- in_ready = en && (state==IDLE || (state==DATA && bit_cnt==DATA_W-1)).
- Accept occurs at a rising edge with in_valid && in_ready. On that edge:
  - latch in_data into the shift register;
  - state -> SYNC, bit_cnt=0;
  - dout <= SYNC_PAT[SYNC_W-1], dout_en <= 1.
- Latency: the first frame bit is visible in the cycle right after the accepting edge. A frame occupies exactly SYNC_W+DATA_W consecutive dout_en cycles (24 at defaults).
- SYNC: each edge shifts out the next sync bit, MSB to LSB. After SYNC_W bits the state goes to DATA, bit_cnt=0, and dout takes in_data[DATA_W-1].
- DATA: each edge shifts out the next payload bit. frame_done=1 and frame_cnt+=1 (mod 2^CNT_W) are registered so they coincide with the cycle the last payload bit is on dout.
- End of DATA, at the edge after the last bit:
  - if a word is accepted on that edge, go directly to SYNC with a new frame. There is no idle cycle, and dout_en stays 1.
  - otherwise go to IDLE with dout=0 and dout_en=0.
- en low: in_ready=0. A frame already in progress completes unaffected. in_valid/in_data are held by the source; nothing is dropped.
- in_valid low during IDLE: outputs hold 0. There are no spurious dout_en pulses.
- in_data changes while in_ready=0 are ignored. Only the value at the accepting edge is sent.
- Simultaneous en fall and last-bit edge: in_ready is already 0, so the block goes to IDLE.
- frame_cnt wraps from 2^CNT_W-1 to 0, with no saturation flag.
- state values 3 are unreachable. If entered, the block goes to IDLE on the next edge with outputs 0.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> dout=0, dout_en=0, frame_done=0, frame_cnt=0, state=0, in_ready=0. Release with en=1 -> in_ready=1.
- Single frame: en=1, in_data=16'hB5C3, one-cycle in_valid.
  - dout over 24 cycles = 10100111_1011010111000011 with dout_en=1 throughout.
  - frame_done high only in cycle 24; frame_cnt=1.
  - in_ready=0 in cycles 1-23, then IDLE with dout_en=0.
- Back-to-back: send 16'hFFFF then 16'h0001 with in_valid held high.
  - 48 contiguous dout_en cycles, the second SYNC starting the cycle after the first frame's last bit.
  - frame_done pulses at cycles 24 and 48; frame_cnt=2.
- Enable drop: en=0 at bit 5 of a DATA phase, next word pending.
  - Current frame finishes intact; in_ready stays 0 and the pending word is not taken.
  - Restore en=1 -> the word is accepted and its first sync bit appears the next cycle.
- Async reset mid-frame: pulse rst_n low between clock edges during DATA bit 7.
  - dout and dout_en go 0 immediately, without waiting for a clock edge; state=0; frame_cnt=0.
  - After release, a new word transmits a full 24-bit frame.
- Counter wrap: send 256 frames -> frame_cnt reads 0 after the 256th frame_done. Connect dout/dout_en to the lock detector -> lock asserts and stays high across all frames.
